uart_acq_scheduler: RTL and testbench

Sequences UART bit-sampling acquisitions from the configuration held by the control register block. Inputs are the round-down period P, the compensation byte (U round-up periods, D round-down periods per bit) and an enable. The block emits one-cycle acquisition strobes whose spacing alternates between P and P+1 clocks, spread evenly so each bit lasts exactly N*P+U clocks, where N=U+D. It sits between the control register block and the TX/RX shift engines.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_comp_accum.sv | 23 ++
 rtl/uart_acq_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_uart_acq_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART acquisition scheduler.
package uart_pkg;

    localparam int PERIOD_W   = 16;
    localparam int CNT_W      = 4;
    localparam int MIN_PERIOD = 2;
    localparam int ACC_W      = 6;

    // Compensation byte layout: U long periods in the high nibble, D short in the low nibble
    localparam int COMP_U_MSB = 7;
    localparam int COMP_U_LSB = 4;
    localparam int COMP_D_MSB = 3;
    localparam int COMP_D_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/uart_comp_accum.sv
// Error accumulator step: decides whether the next period is long (P+1) and the new residue.
module uart_comp_accum
    import uart_pkg::*;
#(
    parameter int FIELD_W = CNT_W
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [FIELD_W-1:0] u,
    input  logic [FIELD_W:0]   n,
    output logic               isLong,
    output logic [ACC_W-1:0]   accNext
);

    logic [ACC_W-1:0] t;

    // acc < N and U <= N, so t stays below 2N (at most 44) and one subtraction suffices
    always_comb begin
        t       = acc + ACC_W'(u);
        isLong  = (t >= ACC_W'(n));
        accNext = isLong ? (t - ACC_W'(n)) : t;
    end

endmodule

// File: rtl/uart_acq_scheduler.sv
// Issues acquisition strobes so each UART bit lasts N*P+U clocks, long periods evenly spread.
// Define UART_ACQ_BITCNT_EN to add the BitCnt_o completed-bit counter output.
module uart_acq_scheduler #(
    parameter int PERIOD_W   = uart_pkg::PERIOD_W,
    parameter int CNT_W      = uart_pkg::CNT_W,
    parameter int MIN_PERIOD = uart_pkg::MIN_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_Enable_i,
    input  logic                p_BitStart_i,
    input  logic [PERIOD_W-1:0] BaudRateGen_i,
    input  logic [7:0]          BitCompensation_i,
    output logic                p_AcqSig_o,
    output logic                p_BitEnd_o,
    output logic [CNT_W:0]      AcqIndex_o,
    output logic                p_Busy_o,
    output logic                p_CfgErr_o
`ifdef UART_ACQ_BITCNT_EN
    ,
    output logic [3:0]          BitCnt_o
`endif
);

    import uart_pkg::*;

    state_t              stateReg, stateNext;
    logic [PERIOD_W-1:0] cntReg, cntNext, pReg, pNext, pSel, loadVal;
    logic [ACC_W-1:0]    accReg, accNext, accSel, accCalc;
    logic [CNT_W-1:0]    uReg, uNext, uSel, newU, newD;
    logic [CNT_W:0]      nReg, nNext, nSel, newN;
    logic [CNT_W:0]      idxReg, idxNext, idxOutReg, idxOutNext;
    logic                acqReg, acqNext, bitEndReg, bitEndNext, errReg, errNext;
    logic                isLong, newValid, expire, lastIdx, freshBit;

    // Period source: live inputs when a new bit begins from a fresh snapshot, else the held snapshot
    always_comb begin
        newU     = BitCompensation_i[COMP_U_MSB:COMP_U_LSB];
        newD     = BitCompensation_i[COMP_D_MSB:COMP_D_LSB];
        newN     = {1'b0, newU} + {1'b0, newD};
        newValid = (newN != '0) && (BaudRateGen_i >= PERIOD_W'(MIN_PERIOD));
        expire   = (cntReg == '0);
        lastIdx  = (idxReg == nReg - 1'b1);
        freshBit = (stateReg == ST_IDLE) || (expire && lastIdx && !p_BitStart_i);
        if (freshBit) begin
            accSel = '0;
            uSel   = newU;
            nSel   = newN;
            pSel   = BaudRateGen_i;
        end else begin
            accSel = p_BitStart_i ? '0 : accReg;
            uSel   = uReg;
            nSel   = nReg;
            pSel   = pReg;
        end
    end

    uart_comp_accum #(
        .FIELD_W (CNT_W)
    ) u_accum (
        .acc     (accSel),
        .u       (uSel),
        .n       (nSel),
        .isLong  (isLong),
        .accNext (accCalc)
    );

    // Counter holds L-1 so a P+1 period still fits in PERIOD_W bits
    assign loadVal = isLong ? pSel : (pSel - 1'b1);

    always_comb begin
        stateNext  = stateReg;
        cntNext    = cntReg;
        accNext    = accReg;
        idxNext    = idxReg;
        pNext      = pReg;
        uNext      = uReg;
        nNext      = nReg;
        acqNext    = 1'b0;
        bitEndNext = 1'b0;
        idxOutNext = idxOutReg;
        errNext    = errReg;

        if (!p_Enable_i) begin
            stateNext = ST_IDLE;
            errNext   = 1'b0;
            cntNext   = '0;
            accNext   = '0;
            idxNext   = '0;
        end else if (stateReg == ST_IDLE) begin
            pNext   = BaudRateGen_i;
            uNext   = newU;
            nNext   = newN;
            idxNext = '0;
            if (newValid) begin
                stateNext = ST_RUN;
                cntNext   = loadVal;
                accNext   = accCalc;
            end else begin
                errNext = 1'b1;
            end
        end else if (p_BitStart_i) begin
            idxNext = '0;
            cntNext = loadVal;
            accNext = accCalc;
        end else if (expire) begin
            acqNext    = 1'b1;
            bitEndNext = lastIdx;
            idxOutNext = idxReg;
            if (lastIdx) begin
                idxNext = '0;
                pNext   = BaudRateGen_i;
                uNext   = newU;
                nNext   = newN;
                if (newValid) begin
                    cntNext = loadVal;
                    accNext = accCalc;
                end else begin
                    stateNext = ST_IDLE;
                    errNext   = 1'b1;
                    cntNext   = '0;
                    accNext   = '0;
                end
            end else begin
                idxNext = idxReg + 1'b1;
                cntNext = loadVal;
                accNext = accCalc;
            end
        end else begin
            cntNext = cntReg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg  <= ST_IDLE;
            cntReg    <= '0;
            accReg    <= '0;
            idxReg    <= '0;
            pReg      <= '0;
            uReg      <= '0;
            nReg      <= '0;
            acqReg    <= 1'b0;
            bitEndReg <= 1'b0;
            idxOutReg <= '0;
            errReg    <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            cntReg    <= cntNext;
            accReg    <= accNext;
            idxReg    <= idxNext;
            pReg      <= pNext;
            uReg      <= uNext;
            nReg      <= nNext;
            acqReg    <= acqNext;
            bitEndReg <= bitEndNext;
            idxOutReg <= idxOutNext;
            errReg    <= errNext;
        end
    end

    assign p_AcqSig_o = acqReg;
    assign p_BitEnd_o = bitEndReg;
    assign AcqIndex_o = idxOutReg;
    assign p_Busy_o   = (stateReg == ST_RUN);
    assign p_CfgErr_o = errReg;

`ifdef UART_ACQ_BITCNT_EN
    logic [3:0] bitCntReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitCntReg <= '0;
        end else if (!p_Enable_i || stateReg == ST_IDLE || p_BitStart_i) begin
            bitCntReg <= '0;
        end else if (bitEndNext) begin
            bitCntReg <= bitCntReg + 4'd1;
        end
    end

    assign BitCnt_o = bitCntReg;
`endif

endmodule

// File: tb/tb_uart_acq_scheduler.sv
// Randomized bench with a closed-form period model plus directed timing checks.
module tb_uart_acq_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        bs = 1'b0;
    logic [15:0] baud = '0;
    logic [7:0]  comp = '0;
    logic        acq, bitEnd, busy, cfgErr;
    logic [4:0]  acqIdx;
`ifdef UART_ACQ_BITCNT_EN
    logic [3:0]  bitCnt;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    uart_acq_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .p_Enable_i        (en),
        .p_BitStart_i      (bs),
        .BaudRateGen_i     (baud),
        .BitCompensation_i (comp),
        .p_AcqSig_o        (acq),
        .p_BitEnd_o        (bitEnd),
        .AcqIndex_o        (acqIdx),
        .p_Busy_o          (busy),
        .p_CfgErr_o        (cfgErr)
`ifdef UART_ACQ_BITCNT_EN
        ,
        .BitCnt_o          (bitCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Period k of a bit is long iff floor((k+1)U/N) steps past floor(kU/N)
    function automatic int periodLen(input int p, input int u, input int n, input int k);
        return p + ((k + 1) * u) / n - (k * u) / n;
    endfunction

    bit mRun, mErr, eAcq, eEnd;
    int mP, mU, mN, mK, mDue, eIdx, eBitCnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mRun = 0; mErr = 0; eAcq = 0; eEnd = 0; eIdx = 0; eBitCnt = 0; mK = 0;
        end else begin
            int n;
            cyc++;
            eAcq = 0;
            eEnd = 0;
            n = int'(comp[7:4]) + int'(comp[3:0]);
            if (!en) begin
                mRun = 0; mErr = 0; eBitCnt = 0;
            end else if (!mRun) begin
                eBitCnt = 0;
                if (n > 0 && baud >= 2) begin
                    mRun = 1; mP = baud; mU = comp[7:4]; mN = n; mK = 0;
                    mDue = cyc + periodLen(mP, mU, mN, 0);
                end else begin
                    mErr = 1;
                end
            end else if (bs) begin
                mK = 0; eBitCnt = 0;
                mDue = cyc + periodLen(mP, mU, mN, 0);
            end else if (cyc == mDue) begin
                eAcq = 1;
                eIdx = mK;
                if (mK == mN - 1) begin
                    eEnd = 1;
                    eBitCnt = (eBitCnt + 1) % 16;
                    mP = baud; mU = comp[7:4]; mN = n; mK = 0;
                    if (n > 0 && baud >= 2) mDue = cyc + periodLen(mP, mU, mN, 0);
                    else begin mRun = 0; mErr = 1; end
                end else begin
                    mK++;
                    mDue = cyc + periodLen(mP, mU, mN, mK);
                end
            end
        end
    end

    always @(negedge clk) begin
        check("acq", int'(acq), int'(eAcq));
        check("bitEnd", int'(bitEnd), int'(eEnd));
        check("busy", int'(busy), int'(mRun));
        check("cfgErr", int'(cfgErr), int'(mErr));
        if (eAcq) check("acqIdx", int'(acqIdx), eIdx);
`ifdef UART_ACQ_BITCNT_EN
        check("bitCnt", int'(bitCnt), eBitCnt);
`endif
    end

    int acqT[$], acqI[$], endT[$], endI[$];
    always @(negedge clk) begin
        if (rst && acq) begin acqT.push_back(cyc); acqI.push_back(int'(acqIdx)); end
        if (rst && bitEnd) begin endT.push_back(cyc); endI.push_back(int'(acqIdx)); end
    end

    function automatic int posAfter(input int q[$], input int from, input int k);
        int c = 0;
        int res = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] >= from && res < 0) begin
                if (c == k) res = i;
                c++;
            end
        end
        return res;
    endfunction

    function automatic int get(input int q[$], input int i);
        return (i < 0) ? -99999 : q[i];
    endfunction

    task automatic waitAcq(input int idx, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (acq && (idx < 0 || int'(acqIdx) == idx)) ok = 1;
        end
    endtask

    task automatic stopRun();
        @(negedge clk);
        en = 0;
        bs = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic randCfg();
        baud = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom_range(2, 10));
        comp = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    endtask

    initial begin
        int e0, t0, t1, t2, p, b0, b1, bsE;
        bit ok;

        #1 rst = 0;
        repeat (3) @(negedge clk);
        check("rst_acq", int'(acq), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(cfgErr), 0);
        check("rst_idx", int'(acqIdx), 0);
        @(posedge clk);
        #2 rst = 1;

        // P=20 U=10 D=5
        @(negedge clk);
        baud = 20; comp = 8'hA5; en = 1; e0 = cyc + 1;
        repeat (700) @(negedge clk);
        #1;
        t0 = get(acqT, posAfter(acqT, e0, 0));
        t1 = get(acqT, posAfter(acqT, e0, 1));
        t2 = get(acqT, posAfter(acqT, e0, 2));
        check("A_first", t0 - e0, 20);
        check("A_gap1", t1 - t0, 21);
        check("A_gap2", t2 - t1, 21);
        b0 = get(endT, posAfter(endT, e0, 0));
        b1 = get(endT, posAfter(endT, e0, 1));
        check("A_bit0", b0 - e0, 310);
        check("A_bitw", b1 - b0, 310);
        check("A_endIdx", get(endI, posAfter(endT, e0, 0)), 14);
        stopRun();

        // P=4 U=0 D=8
        baud = 4; comp = 8'h08; en = 1; e0 = cyc + 1;
        repeat (100) @(negedge clk);
        #1;
        check("B_first", get(acqT, posAfter(acqT, e0, 0)) - e0, 4);
        b0 = get(endT, posAfter(endT, e0, 0));
        b1 = get(endT, posAfter(endT, e0, 1));
        check("B_bitw", b1 - b0, 32);
        check("B_endIdx", get(endI, posAfter(endT, e0, 0)), 7);
        stopRun();

        // P=3 U=15 D=15: N=30 must not wrap
        baud = 3; comp = 8'hFF; en = 1; e0 = cyc + 1;
        repeat (250) @(negedge clk);
        #1;
        b0 = get(endT, posAfter(endT, e0, 0));
        b1 = get(endT, posAfter(endT, e0, 1));
        check("C_bit0", b0 - e0, 105);
        check("C_bitw", b1 - b0, 105);
        check("C_endIdx", get(endI, posAfter(endT, e0, 0)), 29);
        stopRun();

        // Invalid configurations
        baud = 1; comp = 8'h55; en = 1; e0 = cyc + 1;
        repeat (10) @(negedge clk);
        check("D_errP", int'(cfgErr), 1);
        check("D_busyP", int'(busy), 0);
        check("D_noAcqP", posAfter(acqT, e0, 0), -1);
        en = 0;
        @(negedge clk);
        check("D_errClr", int'(cfgErr), 0);
        baud = 6; comp = 8'h00; en = 1; e0 = cyc + 1;
        repeat (10) @(negedge clk);
        check("D_errN", int'(cfgErr), 1);
        check("D_noAcqN", posAfter(acqT, e0, 0), -1);
        stopRun();

        // Resync 7 cycles after the index-5 strobe
        baud = 20; comp = 8'hA5; en = 1;
        waitAcq(5, 400, ok);
        check("E_wait", int'(ok), 1);
        repeat (6) @(negedge clk);
        bs = 1; bsE = cyc + 1;
        @(negedge clk);
        bs = 0;
        repeat (40) @(negedge clk);
        #1;
        p = posAfter(acqT, bsE, 0);
        check("E_next", get(acqT, p) - bsE, 20);
        check("E_idx", get(acqI, p), 0);
        stopRun();

        // Enable drops on the expiry cycle
        baud = 4; comp = 8'h08; en = 1;
        waitAcq(-1, 50, ok);
        check("F_wait", int'(ok), 1);
        repeat (3) @(negedge clk);
        en = 0;
        @(negedge clk);
        check("F_noAcq", int'(acq), 0);
        check("F_busy", int'(busy), 0);
        repeat (2) @(negedge clk);

        // Mid-bit config change waits for the bit boundary
        baud = 20; comp = 8'hA5; en = 1; e0 = cyc + 1;
        waitAcq(3, 200, ok);
        check("G_wait", int'(ok), 1);
        baud = 4; comp = 8'h08;
        repeat (300) @(negedge clk);
        #1;
        b0 = get(endT, posAfter(endT, e0, 0));
        check("G_bit0", b0 - e0, 310);
        check("G_newGap", get(acqT, posAfter(acqT, b0 + 1, 0)) - b0, 4);
        stopRun();

        // Randomized traffic with an asynchronous reset mid-run
        for (int r = 0; r < 25; r++) begin
            randCfg();
            en = 1;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                bs = ($urandom_range(0, 149) == 0);
                en = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 99) == 0) randCfg();
                if (r == 12 && c == 200) begin
                    @(posedge clk);
                    #2 rst = 0;
                    #1;
                    check("R_rstBusy", int'(busy), 0);
                    check("R_rstAcq", int'(acq), 0);
                    @(posedge clk);
                    #2 rst = 1;
                end
            end
            stopRun();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
